// File: rtl/bus_datos_io.sv
// Data-side memory and I/O block behind the single-cycle core: word RAM, LED
// register, compare timer with sticky flag, and a transmit-only UART.
module bus_datos_io #(
  parameter int RAM_WORDS = 64,
  parameter int CLK_DIV   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic        uart_tx,
  output logic        timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [2:0] SEL_LED   = 3'd0;
  localparam logic [2:0] SEL_CNT   = 3'd1;
  localparam logic [2:0] SEL_CMP   = 3'd2;
  localparam logic [2:0] SEL_UDATA = 3'd3;
  localparam logic [2:0] SEL_USTAT = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;

  logic [31:0]    mem [RAM_WORDS];
  logic           is_io;
  logic [2:0]     io_sel;
  logic [AW-1:0]  ram_idx;

  logic           wr_ram;
  logic           wr_led;
  logic           wr_cnt;
  logic           wr_cmp;
  logic           wr_udata;
  logic           wr_ustat;

  logic [31:0]    cnt;
  logic [31:0]    cmp;

  uart_state_t    state;
  logic [DW-1:0]  div;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           busy;
  logic           overrun;
  logic           bit_end;

  // Bits above the RAM index are don't-care so the RAM aliases; byte offset is ignored.
  logic           unused_addr;
  assign unused_addr = ^{ALUResult[30:5], ALUResult[1:0]};

  assign is_io   = ALUResult[31];
  assign io_sel  = ALUResult[4:2];
  assign ram_idx = ALUResult[AW+1:2];

  assign wr_ram   = MemWrite && !is_io;
  assign wr_led   = MemWrite && is_io && (io_sel == SEL_LED);
  assign wr_cnt   = MemWrite && is_io && (io_sel == SEL_CNT);
  assign wr_cmp   = MemWrite && is_io && (io_sel == SEL_CMP);
  assign wr_udata = MemWrite && is_io && (io_sel == SEL_UDATA);
  assign wr_ustat = MemWrite && is_io && (io_sel == SEL_USTAT);

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      mem[ram_idx] <= WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds <= '0;
    end else if (wr_led) begin
      leds <= WriteData[7:0];
    end
  end

  // A compare write still lets the count rule run against the old compare value;
  // its flag clear takes precedence over a match on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      cmp       <= '0;
      timer_irq <= 1'b0;
    end else begin
      if (wr_cnt) begin
        cnt <= WriteData;
      end else if ((cmp != '0) && (cnt == cmp)) begin
        cnt       <= '0;
        timer_irq <= 1'b1;
      end else begin
        cnt <= cnt + 32'd1;
      end
      if (wr_cmp) begin
        cmp       <= WriteData;
        timer_irq <= 1'b0;
      end
    end
  end

  assign bit_end = (div == DIV_LAST);

  // busy stays high through the final STOP edge, so a write on that edge overruns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      div     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      uart_tx <= 1'b1;
    end else begin
      if (wr_udata && busy) begin
        overrun <= 1'b1;
      end else if (wr_ustat) begin
        overrun <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (wr_udata) begin
            shreg   <= WriteData[7:0];
            busy    <= 1'b1;
            div     <= '0;
            uart_tx <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            div     <= '0;
            bit_idx <= '0;
            uart_tx <= shreg[0];
            state   <= S_DATA;
          end else begin
            div <= div + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            div <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shreg[bit_idx + 3'd1];
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            div   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ReadData = '0;
    if (!is_io) begin
      ReadData = mem[ram_idx];
    end else begin
      case (io_sel)
        SEL_LED:   ReadData = {24'b0, leds};
        SEL_CNT:   ReadData = cnt;
        SEL_CMP:   ReadData = cmp;
        SEL_UDATA: ReadData = '0;
        SEL_USTAT: ReadData = {29'b0, timer_irq, overrun, busy};
        default:   ReadData = '0;
      endcase
    end
  end

endmodule
